// File: rtl/branch_resolver.sv
// Execute-side branch resolver: an in-order queue of pending branches that
// captures CDB operands by tag and reports the head's real outcome.
module branch_resolver #(
  parameter int DEPTH  = 4,
  parameter int RSID_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_pc,
  input  logic [2:0]        in_cond,
  input  logic              in_op1_is_rsid,
  input  logic              in_op2_is_rsid,
  input  logic [31:0]       in_op1,
  input  logic [31:0]       in_op2,
  input  logic [31:0]       in_target,
  input  logic              in_pred_taken,
  input  logic [31:0]       in_pred_target,
  input  logic              cdb_valid,
  input  logic [RSID_W-1:0] cdb_rsid,
  input  logic [31:0]       cdb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_pc,
  output logic              out_taken,
  output logic [31:0]       out_target,
  output logic              out_mispredict
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [2:0] C_JR   = 3'd0;
  localparam logic [2:0] C_BEQ  = 3'd1;
  localparam logic [2:0] C_BNE  = 3'd2;
  localparam logic [2:0] C_BGTZ = 3'd3;
  localparam logic [2:0] C_BLEZ = 3'd4;
  localparam logic [2:0] C_BLTZ = 3'd5;
  localparam logic [2:0] C_BGEZ = 3'd6;

  function automatic logic resolve_taken(input logic [2:0] cond,
                                         input logic signed [31:0] a,
                                         input logic signed [31:0] b);
    logic a_zero;
    a_zero = (a == 32'sd0);
    case (cond)
      C_JR:    resolve_taken = 1'b1;
      C_BEQ:   resolve_taken = (a == b);
      C_BNE:   resolve_taken = (a != b);
      C_BGTZ:  resolve_taken = !a[31] && !a_zero;
      C_BLEZ:  resolve_taken = a[31] || a_zero;
      C_BLTZ:  resolve_taken = a[31];
      C_BGEZ:  resolve_taken = !a[31];
      default: resolve_taken = 1'b0;
    endcase
  endfunction

  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [DEPTH-1:0] op1_rsid_q, op1_rsid_d, op2_rsid_q, op2_rsid_d;

  logic [31:0] pc_q   [DEPTH];
  logic [2:0]  cond_q [DEPTH];
  logic [31:0] op1_q  [DEPTH];
  logic [31:0] op2_q  [DEPTH];
  logic [31:0] op1_d  [DEPTH];
  logic [31:0] op2_d  [DEPTH];
  logic [31:0] tgt_q  [DEPTH];
  logic        pt_q   [DEPTH];
  logic [31:0] ptgt_q [DEPTH];

  logic enq, deq, byp1, byp2;
  logic h_ready, h_taken, h_mis;
  logic [31:0] h_target;
  logic [2:0]  h_cond;

  assign in_ready = !rst && !flush && (count_q < CNT_W'(DEPTH));
  assign enq      = in_valid && in_ready;
  assign deq      = out_valid && out_ready;
  assign byp1     = cdb_valid && in_op1_is_rsid && (in_op1[RSID_W-1:0] == cdb_rsid);
  assign byp2     = cdb_valid && in_op2_is_rsid && (in_op2[RSID_W-1:0] == cdb_rsid);

  // Head resolution: op2 only gates readiness for the two-operand compares.
  always_comb begin
    h_cond   = cond_q[head_q];
    h_ready  = !op1_rsid_q[head_q] &&
               (!((h_cond == C_BEQ) || (h_cond == C_BNE)) || !op2_rsid_q[head_q]);
    h_taken  = resolve_taken(h_cond, op1_q[head_q], op2_q[head_q]);
    if (h_cond == C_JR)
      h_target = op1_q[head_q];
    else if (h_taken)
      h_target = tgt_q[head_q];
    else
      h_target = pc_q[head_q] + 32'd8;
    h_mis = (pt_q[head_q] != h_taken) || (h_taken && (ptgt_q[head_q] != h_target));

    out_valid      = (count_q != '0) && h_ready && !flush;
    out_pc         = out_valid ? pc_q[head_q] : 32'd0;
    out_taken      = out_valid && h_taken;
    out_target     = out_valid ? h_target : 32'd0;
    out_mispredict = out_valid && h_mis;
  end

  // Operand capture: the enqueue slot takes the incoming operand (with
  // same-cycle CDB bypass); every other slot snoops the CDB for its tags.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      op1_d[i]      = op1_q[i];
      op2_d[i]      = op2_q[i];
      op1_rsid_d[i] = op1_rsid_q[i];
      op2_rsid_d[i] = op2_rsid_q[i];
      if (!flush) begin
        if (enq && (tail_q == PTR_W'(i))) begin
          op1_d[i]      = byp1 ? cdb_data : in_op1;
          op2_d[i]      = byp2 ? cdb_data : in_op2;
          op1_rsid_d[i] = in_op1_is_rsid && !byp1;
          op2_rsid_d[i] = in_op2_is_rsid && !byp2;
        end else if (cdb_valid) begin
          if (op1_rsid_q[i] && (op1_q[i][RSID_W-1:0] == cdb_rsid)) begin
            op1_d[i]      = cdb_data;
            op1_rsid_d[i] = 1'b0;
          end
          if (op2_rsid_q[i] && (op2_q[i][RSID_W-1:0] == cdb_rsid)) begin
            op2_d[i]      = cdb_data;
            op2_rsid_d[i] = 1'b0;
          end
        end
      end
    end
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (enq) tail_d = tail_q + PTR_W'(1);
      if (deq) head_d = head_q + PTR_W'(1);
      case ({enq, deq})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      op1_rsid_q <= '0;
      op2_rsid_q <= '0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      op1_rsid_q <= op1_rsid_d;
      op2_rsid_q <= op2_rsid_d;
    end
  end

  // Payload storage carries no reset; slot occupancy is tracked by count.
  always_ff @(posedge clk) begin
    op1_q <= op1_d;
    op2_q <= op2_d;
    if (enq) begin
      pc_q[tail_q]   <= in_pc;
      cond_q[tail_q] <= in_cond;
      tgt_q[tail_q]  <= in_target;
      pt_q[tail_q]   <= in_pred_taken;
      ptgt_q[tail_q] <= in_pred_target;
    end
  end
endmodule

// File: tb/tb_branch_resolver.sv
// Self-checking bench for branch_resolver: directed vectors, corner-case
// sequences, and a randomized run against a queue-based reference model.
module tb_branch_resolver;
  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready;
  logic [31:0] in_pc, in_op1, in_op2, in_target, in_pred_target;
  logic [2:0]  in_cond;
  logic        in_op1_is_rsid, in_op2_is_rsid, in_pred_taken;
  logic        cdb_valid;
  logic [3:0]  cdb_rsid;
  logic [31:0] cdb_data;
  logic        out_valid, out_ready, out_taken, out_mispredict;
  logic [31:0] out_pc, out_target;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  branch_resolver #(.DEPTH(4), .RSID_W(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_cond(in_cond),
    .in_op1_is_rsid(in_op1_is_rsid), .in_op2_is_rsid(in_op2_is_rsid),
    .in_op1(in_op1), .in_op2(in_op2), .in_target(in_target),
    .in_pred_taken(in_pred_taken), .in_pred_target(in_pred_target),
    .cdb_valid(cdb_valid), .cdb_rsid(cdb_rsid), .cdb_data(cdb_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_taken(out_taken), .out_target(out_target), .out_mispredict(out_mispredict)
  );

  typedef struct {
    logic [2:0]  cond;
    logic [31:0] op1, op2;
    logic        r2;
    logic [31:0] pc, tgt;
    logic        pt;
    logic [31:0] ptgt;
    logic        et;
    logic [31:0] etgt;
    logic        emis;
  } vec_t;

  typedef struct {
    logic [2:0]  cond;
    logic [31:0] op1, op2;
    logic        r1, r2;
    logic [31:0] pc, tgt;
    logic        pt;
    logic [31:0] ptgt;
  } ent_t;

  vec_t tv[10];
  ent_t mq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [2:0] c, input logic [31:0] a, input logic ra,
                        input logic [31:0] b, input logic rb, input logic [31:0] pc,
                        input logic [31:0] tgt, input logic pt, input logic [31:0] ptgt);
    in_valid = 1'b1; in_cond = c; in_op1 = a; in_op1_is_rsid = ra;
    in_op2 = b; in_op2_is_rsid = rb; in_pc = pc; in_target = tgt;
    in_pred_taken = pt; in_pred_target = ptgt;
  endtask

  task automatic clear_in();
    in_valid = 1'b0; in_op1_is_rsid = 1'b0; in_op2_is_rsid = 1'b0;
  endtask

  task automatic chk_out(input string nm, input logic [31:0] pc, input logic t,
                         input logic [31:0] tgt, input logic mis);
    chk({nm, ".valid"}, out_valid, 1);
    chk({nm, ".pc"}, out_pc, pc);
    chk({nm, ".taken"}, out_taken, t);
    chk({nm, ".target"}, out_target, tgt);
    chk({nm, ".mispredict"}, out_mispredict, mis);
  endtask

  // Reference model: direction and target from the plain signed rules.
  function automatic logic m_taken(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
    case (c)
      3'd0: return 1'b1;
      3'd1: return a == b;
      3'd2: return a != b;
      3'd3: return $signed(a) > 0;
      3'd4: return $signed(a) <= 0;
      3'd5: return $signed(a) < 0;
      3'd6: return $signed(a) >= 0;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic m_ready(input ent_t e);
    if (e.r1) return 1'b0;
    if ((e.cond == 3'd1 || e.cond == 3'd2) && e.r2) return 1'b0;
    return 1'b1;
  endfunction

  logic [31:0] vals[6];

  initial begin
    vals[0] = 32'd0; vals[1] = 32'd1; vals[2] = 32'd5;
    vals[3] = 32'hFFFF_FFFF; vals[4] = 32'h8000_0000; vals[5] = 32'h7FFF_FFFF;
    //          cond  op1            op2   r2  pc             tgt            pt  ptgt           et  etgt           emis
    tv[0] = '{3'd1, 32'd5,         32'd5, 0, 32'h1000,     32'h1040,     0, 32'h0,        1, 32'h1040,     1};
    tv[1] = '{3'd2, 32'd5,         32'd5, 0, 32'h1100,     32'h1180,     0, 32'h0,        0, 32'h1108,     0};
    tv[2] = '{3'd3, 32'd0,         32'd0, 0, 32'h1200,     32'h1300,     1, 32'h1300,     0, 32'h1208,     1};
    tv[3] = '{3'd4, 32'd0,         32'd0, 0, 32'h1300,     32'h1400,     1, 32'h1400,     1, 32'h1400,     0};
    tv[4] = '{3'd5, 32'h8000_0000, 32'd0, 0, 32'h1400,     32'h1500,     1, 32'h1504,     1, 32'h1500,     1};
    tv[5] = '{3'd6, 32'h8000_0000, 32'd0, 0, 32'h1500,     32'h1600,     0, 32'h0,        0, 32'h1508,     0};
    tv[6] = '{3'd0, 32'h1234_5678, 32'd0, 0, 32'h1600,     32'h0000_DEAD,1, 32'h1234_5678,1, 32'h1234_5678,0};
    tv[7] = '{3'd7, 32'd1,         32'd1, 0, 32'hFFFF_FFFC,32'h10,       0, 32'h0,        0, 32'h0000_0004,0};
    tv[8] = '{3'd3, 32'd1,         32'd7, 1, 32'h1800,     32'h1900,     1, 32'h1900,     1, 32'h1900,     0};
    tv[9] = '{3'd2, 32'd1,         32'd2, 0, 32'h1900,     32'h1A00,     0, 32'h0,        1, 32'h1A00,     1};

    rst = 1'b1; flush = 1'b0; clear_in(); in_pc = 0; in_cond = 0; in_op1 = 0; in_op2 = 0;
    in_target = 0; in_pred_taken = 0; in_pred_target = 0;
    cdb_valid = 0; cdb_rsid = 0; cdb_data = 0; out_ready = 0;
    #2;
    chk("reset.in_ready", in_ready, 0);
    chk("reset.out_valid", out_valid, 0);
    chk("reset.out_pc", out_pc, 0);
    chk("reset.out_target", out_target, 0);
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("release.in_ready", in_ready, 1);
    chk("release.out_valid", out_valid, 0);

    // Directed single-branch vectors, all operands already values.
    tick();
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      set_in(tv[i].cond, tv[i].op1, 1'b0, tv[i].op2, tv[i].r2, tv[i].pc, tv[i].tgt,
             tv[i].pt, tv[i].ptgt);
      #1;
      chk($sformatf("vec%0d.pre_valid", i), out_valid, 0);
      tick();
      clear_in();
      #1;
      chk_out($sformatf("vec%0d", i), tv[i].pc, tv[i].et, tv[i].etgt, tv[i].emis);
      tick();
    end
    #1;
    chk("vec.drained", out_valid, 0);

    // BGTZ waiting on tag 3, broadcast two cycles later.
    tick();
    set_in(3'd3, 32'd3, 1'b1, 32'd0, 1'b0, 32'h2000, 32'h2100, 1'b0, 32'h0);
    tick(); clear_in(); #1;
    chk("bgtz.wait0", out_valid, 0);
    tick(); #1;
    chk("bgtz.wait1", out_valid, 0);
    cdb_valid = 1'b1; cdb_rsid = 4'd3; cdb_data = 32'hFFFF_FFFF;
    #1;
    chk("bgtz.bcast_cycle", out_valid, 0);
    tick(); cdb_valid = 1'b0; #1;
    chk_out("bgtz", 32'h2000, 1'b0, 32'h2008, 1'b0);
    tick();

    // JR whose tag is broadcast in the enqueue cycle.
    set_in(3'd0, 32'd2, 1'b1, 32'd0, 1'b0, 32'h2800, 32'h0, 1'b1, 32'h8000_0100);
    cdb_valid = 1'b1; cdb_rsid = 4'd2; cdb_data = 32'h8000_0100;
    tick(); clear_in(); cdb_valid = 1'b0; #1;
    chk_out("jr_bypass", 32'h2800, 1'b1, 32'h8000_0100, 1'b0);
    tick();

    // Full queue with a blocked head, then in-order drain under stalls.
    out_ready = 1'b0;
    set_in(3'd0, 32'd5, 1'b1, 32'd0, 1'b0, 32'h3000, 32'h0, 1'b1, 32'h4000);
    tick();
    set_in(3'd1, 32'd1, 1'b0, 32'd1, 1'b0, 32'h3004, 32'h3100, 1'b1, 32'h3100);
    tick();
    set_in(3'd2, 32'd1, 1'b0, 32'd1, 1'b0, 32'h3008, 32'h3200, 1'b1, 32'h3200);
    tick();
    set_in(3'd5, 32'hFFFF_FFFC, 1'b0, 32'd0, 1'b0, 32'h300C, 32'h3300, 1'b0, 32'h0);
    tick(); clear_in(); #1;
    chk("full.in_ready", in_ready, 0);
    chk("full.out_valid", out_valid, 0);
    cdb_valid = 1'b1; cdb_rsid = 4'd5; cdb_data = 32'h4000;
    #1;
    chk("full.bcast_cycle", out_valid, 0);
    tick(); cdb_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      logic [31:0] epc, etg;
      logic        et, em;
      case (k)
        0: begin epc = 32'h3000; et = 1; etg = 32'h4000; em = 0; end
        1: begin epc = 32'h3004; et = 1; etg = 32'h3100; em = 0; end
        2: begin epc = 32'h3008; et = 0; etg = 32'h3010; em = 1; end
        default: begin epc = 32'h300C; et = 1; etg = 32'h3300; em = 1; end
      endcase
      out_ready = 1'b0; #1;
      chk_out($sformatf("drain%0d.stall", k), epc, et, etg, em);
      tick();
      chk_out($sformatf("drain%0d.held", k), epc, et, etg, em);
      out_ready = 1'b1;
      if (k == 0) set_in(3'd1, 32'd0, 1'b0, 32'd0, 1'b0, 32'h3F00, 32'h3F80, 1'b0, 32'h0);
      #1;
      if (k == 0) chk("drain0.full_in_ready", in_ready, 0);
      tick(); clear_in();
    end
    out_ready = 1'b0; #1;
    chk("drain.empty_valid", out_valid, 0);
    chk("drain.empty_in_ready", in_ready, 1);

    // Flush with three pending and a simultaneous offer.
    for (int k = 0; k < 3; k++) begin
      set_in(3'd1, 32'd9, 1'b0, 32'd9, 1'b0, 32'h4000 + 32'(k * 4), 32'h4800, 1'b1, 32'h4800);
      tick();
    end
    flush = 1'b1;
    set_in(3'd1, 32'd9, 1'b0, 32'd9, 1'b0, 32'h4F00, 32'h4800, 1'b1, 32'h4800);
    #1;
    chk("flush.in_ready", in_ready, 0);
    chk("flush.out_valid", out_valid, 0);
    chk("flush.out_pc", out_pc, 0);
    tick(); flush = 1'b0; clear_in(); #1;
    chk("flush.after_valid", out_valid, 0);
    chk("flush.after_in_ready", in_ready, 1);
    set_in(3'd1, 32'd3, 1'b0, 32'd3, 1'b0, 32'h5000, 32'h5100, 1'b1, 32'h5100);
    tick(); clear_in(); #1;
    chk_out("flush.refill", 32'h5000, 1'b1, 32'h5100, 1'b0);
    out_ready = 1'b1;
    tick(); #1;
    chk("flush.refill_drained", out_valid, 0);

    // Asynchronous reset mid-queue.
    out_ready = 1'b0;
    set_in(3'd0, 32'h6100, 1'b0, 32'd0, 1'b0, 32'h6000, 32'h0, 1'b0, 32'h0);
    tick();
    set_in(3'd0, 32'h6200, 1'b0, 32'd0, 1'b0, 32'h6004, 32'h0, 1'b0, 32'h0);
    tick(); clear_in(); #1;
    chk("arst.pre_pc", out_pc, 32'h6000);
    #2 rst = 1'b1;
    #1;
    chk("arst.valid", out_valid, 0);
    chk("arst.pc", out_pc, 0);
    chk("arst.target", out_target, 0);
    chk("arst.taken", out_taken, 0);
    chk("arst.mispredict", out_mispredict, 0);
    chk("arst.in_ready", in_ready, 0);
    @(negedge clk); #1 rst = 1'b0;
    #1;
    chk("arst.release_in_ready", in_ready, 1);
    chk("arst.release_valid", out_valid, 0);
    tick(); #1;
    chk("arst.entries_gone", out_valid, 0);

    // Randomized traffic against the reference model.
    mq.delete();
    for (int cyc = 0; cyc < 600; cyc++) begin
      logic ev, eir, enq, et;
      logic [31:0] etg;
      ent_t h, ne;
      flush     = ($urandom_range(0, 39) == 0);
      in_valid  = ($urandom_range(0, 2) != 0);
      in_cond   = 3'($urandom_range(0, 7));
      in_op1_is_rsid = ($urandom_range(0, 2) == 0);
      in_op2_is_rsid = ($urandom_range(0, 2) == 0);
      in_op1    = in_op1_is_rsid ? 32'($urandom_range(0, 5)) : vals[$urandom_range(0, 5)];
      in_op2    = in_op2_is_rsid ? 32'($urandom_range(0, 5)) : vals[$urandom_range(0, 5)];
      in_pc     = $urandom() & 32'hFFFF_FFFC;
      in_target = $urandom() & 32'hFFFF_FFFC;
      in_pred_taken  = 1'($urandom_range(0, 1));
      in_pred_target = ($urandom_range(0, 1) == 1) ? in_target : vals[$urandom_range(0, 5)];
      cdb_valid = ($urandom_range(0, 1) == 1);
      cdb_rsid  = 4'($urandom_range(0, 5));
      cdb_data  = vals[$urandom_range(0, 5)];
      out_ready = ($urandom_range(0, 9) < 7);
      #1;
      ev  = (mq.size() != 0) && !flush && m_ready(mq[0]);
      eir = !flush && (mq.size() < 4);
      chk("rnd.in_ready", in_ready, eir);
      chk("rnd.out_valid", out_valid, ev);
      if (ev) begin
        h   = mq[0];
        et  = m_taken(h.cond, h.op1, h.op2);
        etg = (h.cond == 3'd0) ? h.op1 : (et ? h.tgt : h.pc + 32'd8);
        chk("rnd.out_pc", out_pc, h.pc);
        chk("rnd.out_taken", out_taken, et);
        chk("rnd.out_target", out_target, etg);
        chk("rnd.out_mispredict", out_mispredict,
            (h.pt != et) || (et && (h.ptgt != etg)));
      end else begin
        chk("rnd.idle_pc", out_pc, 0);
        chk("rnd.idle_target", out_target, 0);
      end
      enq = in_valid && eir;
      if (flush) begin
        mq.delete();
      end else begin
        if (cdb_valid) begin
          foreach (mq[k]) begin
            if (mq[k].r1 && mq[k].op1[3:0] == cdb_rsid) begin mq[k].op1 = cdb_data; mq[k].r1 = 0; end
            if (mq[k].r2 && mq[k].op2[3:0] == cdb_rsid) begin mq[k].op2 = cdb_data; mq[k].r2 = 0; end
          end
        end
        if (ev && out_ready) void'(mq.pop_front());
        if (enq) begin
          ne.cond = in_cond; ne.pc = in_pc; ne.tgt = in_target;
          ne.pt = in_pred_taken; ne.ptgt = in_pred_target;
          ne.op1 = in_op1; ne.r1 = in_op1_is_rsid;
          ne.op2 = in_op2; ne.r2 = in_op2_is_rsid;
          if (cdb_valid && ne.r1 && ne.op1[3:0] == cdb_rsid) begin ne.op1 = cdb_data; ne.r1 = 0; end
          if (cdb_valid && ne.r2 && ne.op2[3:0] == cdb_rsid) begin ne.op2 = cdb_data; ne.r2 = 0; end
          mq.push_back(ne);
        end
      end
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/branch_resolver.md
# branch_resolver

Resolves conditional branches and register jumps whose operands were not yet available at decode. It is the execute-side consumer of the decode branch-info stream. It holds up to DEPTH pending branches in program order and captures operand values from the common data bus (CDB) by reservation-station id (rsid). For the head entry it computes the real direction and target, then reports the correct next PC and a mispredict flag to commit/fetch through a valid/ready handshake.

## Interface
- DEPTH, 4: pending-branch queue entries (power of two, ≥2).
- RSID_W, 4: rsid tag width; a tag is carried in operand bits [RSID_W-1:0].
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  reset, asynchronous, active-high.
- flush  in  1  discard all pending entries.
- in_valid  in  1  new branch offered.
- in_ready  out  1  queue can accept the branch.
- in_pc  in  32  branch PC.
- in_cond  in  3  0=JR/JALR, 1=BEQ, 2=BNE, 3=BGTZ, 4=BLEZ, 5=BLTZ/BLTZAL, 6=BGEZ/BGEZAL; 7 is reserved and treated as never-taken.
- in_op1_is_rsid, in_op2_is_rsid  in  1 each  operand holds a tag rather than a value.
- in_op1, in_op2  in  32 each  operand value or tag.
- in_target  in  32  branch target (pc+4+offset); ignored for JR.
- in_pred_taken  in  1  fetch prediction.
- in_pred_target  in  32  predicted target.
- cdb_valid  in  1  result broadcast.
- cdb_rsid  in  RSID_W  producing rsid.
- cdb_data  in  32  result value.
- out_valid  out  1  head branch resolved.
- out_ready  in  1  consumer accepts.
- out_pc  out  32  head branch PC.
- out_taken  out  1  actual direction.
- out_target  out  32  correct next PC.
- out_mispredict  out  1  prediction was wrong.

## Operation
- Storage: circular buffer with head/tail pointers and a count (0..DEPTH). Each entry holds pc, cond, op1/op2 (value or tag) with their is_rsid flags, target, pred_taken and pred_target.
- Enqueue on in_valid && in_ready. in_ready = !rst && !flush && count < DEPTH. A full queue never enqueues, even when a dequeue happens in the same cycle.
- Wakeup: every cycle with cdb_valid, each valid entry whose operand is_rsid is set and whose tag equals cdb_rsid stores cdb_data and clears is_rsid. Op1 and op2 match independently.
- Bypass: an enqueued operand whose tag matches a same-cycle CDB broadcast is stored as a value (is_rsid=0).
- Ready: op1 is a value, plus op2 is a value for BEQ/BNE only (op2 is ignored otherwise).
- Direction (signed 32-bit):
  - JR: always taken.
  - BEQ: op1==op2.
  - BNE: op1!=op2.
  - BGTZ: !op1[31] && op1!=0.
  - BLEZ: op1[31] || op1==0.
  - BLTZ: op1[31].
  - BGEZ: !op1[31].
- Target selection:
  - out_target = op1 for JR; in_target when taken; pc+8 (past the delay slot) when not taken. All are 32-bit with wrap-around.
  - out_mispredict = (pred_taken != out_taken) || (out_taken && pred_target != out_target).
- Output: out_valid = count!=0 && head ready && !flush. Only the head is reported; younger ready entries wait. While out_valid=0, out_pc, out_taken, out_target and out_mispredict are 0.
- Dequeue on out_valid && out_ready. Enqueue and dequeue in the same cycle leave count unchanged.
- Flush: at the next edge count, head and tail go to 0. Enqueue, dequeue and wakeup are suppressed that cycle.

## Timing
- Reset (async, immediate): count/head/tail=0; out_valid=0; all out_* data=0; in_ready=0 while rst is high and 1 in the first cycle after release.
- Assertion of rst mid-operation drops all entries immediately. No output is produced for them.
- An entry enqueued with ready operands gives out_valid in the cycle after the enqueue edge, provided it is the head.
- An entry waiting on a tag gives out_valid in the cycle after the CDB broadcast edge.
- out_* are combinational from head registers and flush. They are held stable while out_valid && !out_ready.

## Test plan
- BEQ with op1=op2=5 (values), pred_taken=0, target 0x1040, pc 0x1000 -> next cycle out_valid=1, out_taken=1, out_target=0x1040, out_mispredict=1.
- BGTZ with op1 tag 3, pred_taken=0, pc 0x2000; CDB rsid 3 data 0xFFFFFFFF two cycles later -> out_valid one cycle after the broadcast, out_taken=0, out_target=0x2008, out_mispredict=0.
- JR with op1 tag 2 and enqueue in the same cycle as CDB rsid 2 data 0x8000_0100, pred target 0x8000_0100 -> bypass captured, out_target=0x8000_0100, mispredict=0.
- Fill 4 entries with head waiting on a tag and entries 1-3 ready -> in_ready=0, out_valid=0. Resolve head -> four in-order outputs, with out_ready toggling 1/0 and outputs held stable during stalls.
- Pulse flush with 3 pending entries and a simultaneous in_valid -> no enqueue, count=0 next cycle, out_valid=0.
- Assert rst asynchronously mid-queue -> out_valid and out_* drop to 0 immediately; in_ready=1 the cycle after release.
